axi4_lite_cmd_sequencer: RTL and testbench

//  Upstream command stage for axi4_lite_top. Buffers host read/write commands in a FIFO.

---
 rtl/axi4_lite_pkg.sv | 13 +
 rtl/axi4_lite_cmd_fifo.sv | 42 ++++
 rtl/axi4_lite_cmd_sequencer.sv | 113 +++++++++++
 tb/tb_axi4_lite_cmd_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: shared types and constants for the AXI4-Lite command sequencer
package axi4_lite_pkg;
  localparam int CMD_AW = 32;
  localparam int CMD_DW = 32;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} seq_state_t;
  typedef struct packed {
    logic              write;
    logic [CMD_AW-1:0] addr;
    logic [CMD_DW-1:0] wdata;
  } cmd_t;
endpackage

// File: rtl/axi4_lite_cmd_fifo.sv
// axi4_lite_cmd_fifo: synchronous command FIFO with registered occupancy count
module axi4_lite_cmd_fifo
  import axi4_lite_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic        pop_i,
  input  cmd_t        din_i,
  output cmd_t        dout_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] count_o
);
  cmd_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign dout_o = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/axi4_lite_cmd_sequencer.sv
// axi4_lite_cmd_sequencer: queues host commands and issues them one at a time with timeout
module axi4_lite_cmd_sequencer
  import axi4_lite_pkg::*;
#(
  parameter int DATA_WIDTH = CMD_DW,
  parameter int ADDRESS = CMD_AW,
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDRESS-1:0]    cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  write_s,
  output logic                  read_s,
  output logic [ADDRESS-1:0]    address,
  output logic [DATA_WIDTH-1:0] W_data,
  input  logic                  wr_done,
  input  logic                  rd_done,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic [1:0]            resp_in,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [1:0]            rsp_resp,
  output logic                  busy
);
  localparam int CW = $clog2(TIMEOUT + 1);
  seq_state_t state_q, state_d;
  cmd_t in_cmd, head, cmd_q, cmd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [1:0] rsp_resp_q, rsp_resp_d;
  logic full, empty, pop, match, expired, active;
  logic [$clog2(DEPTH):0] count;
  assign in_cmd = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  axi4_lite_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (ACLK),
    .rst    (ARESET),
    .push_i (cmd_valid),
    .pop_i  (pop),
    .din_i  (in_cmd),
    .dout_o (head),
    .full_o (full),
    .empty_o(empty),
    .count_o(count)
  );
  assign pop = state_q == IDLE && !empty;
  assign match = cmd_q.write ? wr_done : rd_done;
  assign expired = cnt_q == CW'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    cnt_d = state_q == WAIT ? cnt_q + 1'b1 : '0;
    rsp_write_d = rsp_write_q;
    rsp_data_d = rsp_data_q;
    rsp_resp_d = rsp_resp_q;
    case (state_q)
      IDLE: if (!empty) begin
        cmd_d = head;
        state_d = ISSUE;
      end
      ISSUE: state_d = WAIT;
      // a completing handshake takes priority over a coincident timeout
      WAIT: if (match || expired) begin
        state_d = RESP;
        rsp_write_d = cmd_q.write;
        rsp_data_d = match && !cmd_q.write ? rd_data : '0;
        rsp_resp_d = match ? resp_in : RESP_SLVERR;
      end
      RESP: if (rsp_ready) begin
        state_d = IDLE;
        rsp_write_d = 1'b0;
        rsp_data_d = '0;
        rsp_resp_d = RESP_OKAY;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
      cmd_q <= '0;
      cnt_q <= '0;
      rsp_write_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_resp_q <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      cnt_q <= cnt_d;
      rsp_write_q <= rsp_write_d;
      rsp_data_q <= rsp_data_d;
      rsp_resp_q <= rsp_resp_d;
    end
  end
  assign active = state_q == ISSUE || state_q == WAIT;
  assign write_s = state_q == ISSUE && cmd_q.write;
  assign read_s = state_q == ISSUE && !cmd_q.write;
  assign address = active ? cmd_q.addr : '0;
  assign W_data = active ? cmd_q.wdata : '0;
  assign cmd_ready = !full;
  assign rsp_valid = state_q == RESP;
  assign rsp_write = rsp_write_q;
  assign rsp_data = rsp_data_q;
  assign rsp_resp = rsp_resp_q;
  assign busy = state_q != IDLE || count != '0;
endmodule

// File: tb/tb_axi4_lite_cmd_sequencer.sv
// tb_axi4_lite_cmd_sequencer: directed self-checking bench for the command sequencer
module tb_axi4_lite_cmd_sequencer;
  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic write_s, read_s, cmd_ready, rsp_valid, rsp_write, busy;
  logic [31:0] address, W_data, rsp_data;
  logic wr_done = 1'b0, rd_done = 1'b0, rsp_ready = 1'b0;
  logic [31:0] rd_data = '0;
  logic [1:0] resp_in = '0, rsp_resp;
  int total = 0, passed = 0, failed = 0;
  always #5 ACLK = ~ACLK;
  axi4_lite_cmd_sequencer #(.DATA_WIDTH(32), .ADDRESS(32), .DEPTH(4), .TIMEOUT(8)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .write_s(write_s), .read_s(read_s), .address(address), .W_data(W_data),
    .wr_done(wr_done), .rd_done(rd_done), .rd_data(rd_data), .resp_in(resp_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_data(rsp_data), .rsp_resp(rsp_resp), .busy(busy)
  );
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic wr, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr = a;
    cmd_wdata = d;
    step();
    cmd_valid = 1'b0;
  endtask
  task automatic wait_strobe(input logic wr, input string tag);
    int n = 0;
    while (!(wr ? write_s : read_s) && n < 20) begin
      step();
      n++;
    end
    check(tag, wr ? write_s : read_s, 1);
  endtask
  task automatic handshake();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask
  task automatic serve_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
    wait_strobe(1'b0, "rd_strobe");
    check("rd_addr", address, a);
    step();
    check("rd_strobe_1cyc", read_s, 0);
    rd_done = 1'b1;
    rd_data = d;
    resp_in = r;
    step();
    rd_done = 1'b0;
    check("rd_rsp_valid", rsp_valid, 1);
    check("rd_rsp_data", rsp_data, d);
    check("rd_rsp_resp", rsp_resp, r);
    check("rd_rsp_write", rsp_write, 0);
    handshake();
  endtask
  initial begin
    step();
    step();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_strobes", {write_s, read_s}, 0);
    check("rst_address", address, 0);
    ARESET = 1'b0;
    // single write, wr_done four cycles after the strobe
    push(1'b1, 32'd3, 32'd5);
    check("wr_pre_strobe", write_s, 0);
    check("wr_busy", busy, 1);
    step();
    check("wr_strobe", write_s, 1);
    check("wr_addr", address, 3);
    check("wr_data", W_data, 5);
    step();
    for (int i = 0; i < 3; i++) begin
      check("wr_strobe_low", write_s, 0);
      check("wr_addr_held", address, 3);
      check("wr_data_held", W_data, 5);
      step();
    end
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    check("wr_rsp_valid", rsp_valid, 1);
    check("wr_rsp_write", rsp_write, 1);
    check("wr_rsp_resp", rsp_resp, 0);
    check("wr_rsp_data", rsp_data, 0);
    handshake();
    check("wr_done_valid", rsp_valid, 0);
    check("wr_done_busy", busy, 0);
    // stray wr_done during a read
    push(1'b0, 32'h20, 32'h0);
    wait_strobe(1'b0, "stray_strobe");
    step();
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    check("stray_ignored", rsp_valid, 0);
    check("stray_addr_held", address, 32'h20);
    rd_done = 1'b1;
    rd_data = 32'h55;
    resp_in = 2'b00;
    step();
    rd_done = 1'b0;
    check("stray_rsp_valid", rsp_valid, 1);
    check("stray_rsp_data", rsp_data, 32'h55);
    check("stray_rsp_write", rsp_write, 0);
    handshake();
    // blocker occupies the FSM while four reads fill the FIFO
    push(1'b0, 32'h10, 32'h0);
    for (int i = 0; i < 4; i++) push(1'b0, 32'(i), 32'h0);
    check("full_cmd_ready", cmd_ready, 0);
    push(1'b0, 32'h9, 32'h0);
    check("full_still", cmd_ready, 0);
    rd_done = 1'b1;
    rd_data = 32'hAB;
    resp_in = 2'b00;
    step();
    rd_done = 1'b0;
    check("blk_rsp_valid", rsp_valid, 1);
    check("blk_rsp_data", rsp_data, 32'hAB);
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", rsp_valid, 1);
      check("hold_data", rsp_data, 32'hAB);
      check("hold_resp", rsp_resp, 0);
      check("hold_no_strobe", read_s, 0);
    end
    handshake();
    check("post_hs_full", cmd_ready, 0);
    step();
    check("pop_strobe", read_s, 1);
    check("pop_ready", cmd_ready, 1);
    serve_read(32'd0, 32'd2, 2'b00);
    serve_read(32'd1, 32'd3, 2'b10);
    serve_read(32'd2, 32'd4, 2'b00);
    serve_read(32'd3, 32'd5, 2'b00);
    for (int i = 0; i < 6; i++) begin
      check("no_dropped_issue", read_s, 0);
      step();
    end
    check("queue_drained", busy, 0);
    // timeout on a read that never completes
    push(1'b0, 32'h7, 32'h0);
    wait_strobe(1'b0, "to_strobe");
    step();
    for (int i = 1; i < 8; i++) begin
      step();
      check("to_waiting", rsp_valid, 0);
    end
    step();
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_resp", rsp_resp, 2'b10);
    check("to_rsp_data", rsp_data, 0);
    handshake();
    // reset during a write wait with another command queued
    push(1'b1, 32'h44, 32'h99);
    wait_strobe(1'b1, "rst_wr_strobe");
    step();
    push(1'b1, 32'h48, 32'h11);
    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    step();
    check("mid_rst_strobes", {write_s, read_s}, 0);
    check("mid_rst_address", address, 0);
    check("mid_rst_wdata", W_data, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_rsp", {rsp_write, rsp_resp, rsp_data}, 0);
    check("mid_rst_ready", cmd_ready, 1);
    check("mid_rst_busy", busy, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
